// File: rtl/mult_div.sv
// Iterative 32x32 multiply / 32/32 divide unit for the EX stage: one radix-2 step
// per cycle, 32 steps, result in {HI, LO} with done pulsing for one cycle.
module mult_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [5:0]  funct,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic        mult_div_done,
    output logic [63:0] mult_div_result
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        is_sgn_q, is_sgn_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] opb_q, opb_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [63:0] result_q, result_d;

    logic        is_md, start, sgn_op;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_fix;
    logic [32:0] div_shift, div_trial;
    logic        div_fits;
    logic [31:0] div_rem_next, div_quo_next, quo_fix, rem_fix;

    // MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B: bit1 selects divide, bit0 unsigned
    assign is_md  = (funct[5:2] == 4'b0110);
    assign sgn_op = ~funct[0];
    assign start  = (state_q == IDLE) && is_md && !flush;
    assign abs_a  = (sgn_op && operand_1[31]) ? -operand_1 : operand_1;
    assign abs_b  = (sgn_op && operand_2[31]) ? -operand_2 : operand_2;

    // One iteration of each datapath; acc_q[31:0] holds multiplier / dividend-quotient
    always_comb begin
        mul_sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_next     = {mul_sum, acc_q[31:1]};
        div_shift    = {rem_q, acc_q[31]};
        div_trial    = div_shift - {1'b0, opb_q};
        div_fits     = ~div_trial[32];
        div_rem_next = div_fits ? div_trial[31:0] : div_shift[31:0];
        div_quo_next = {acc_q[30:0], div_fits};
    end

    // Sign correction on the final step; divide-by-zero pins LO to all ones
    always_comb begin
        mul_fix = (is_sgn_q && (sign_a_q ^ sign_b_q)) ? -mul_next : mul_next;
        quo_fix = (is_sgn_q && (sign_a_q ^ sign_b_q)) ? -div_quo_next : div_quo_next;
        rem_fix = (is_sgn_q && sign_a_q) ? -div_rem_next : div_rem_next;
        if (div_zero_q) begin
            quo_fix = 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        is_sgn_d   = is_sgn_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        result_d   = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d   = funct[1];
                    is_sgn_d   = sgn_op;
                    sign_a_d   = sgn_op & operand_1[31];
                    sign_b_d   = sgn_op & operand_2[31];
                    div_zero_d = funct[1] && (operand_2 == 32'd0);
                    opb_d      = abs_b;
                    acc_d      = {32'd0, abs_a};
                    rem_d      = 32'd0;
                    cnt_d      = 5'd0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div_q) begin
                    acc_d = {32'd0, div_quo_next};
                    rem_d = div_rem_next;
                end else begin
                    acc_d = mul_next;
                end
                if (cnt_q == 5'd31) begin
                    state_d  = DONE;
                    result_d = is_div_q ? {rem_fix, quo_fix} : mul_fix;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A cancelled op must never publish a result, even on its last step
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = 5'd0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            is_div_q   <= 1'b0;
            is_sgn_q   <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            opb_q      <= 32'd0;
            acc_q      <= 64'd0;
            rem_q      <= 32'd0;
            result_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            is_sgn_q   <= is_sgn_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            result_q   <= result_d;
        end
    end

    assign mult_div_done   = (state_q == DONE);
    assign mult_div_result = result_q;

endmodule

// File: tb/tb_mult_div.sv
// Randomized bench for mult_div against an arithmetic reference model, plus the
// directed latency, flush and reset scenarios.
module tb_mult_div;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [5:0]  funct;
  logic [31:0] op1, op2;
  logic        done;
  logic [63:0] res;
  logic [63:0] last_res;
  int          n_chk = 0;
  int          n_fail = 0;

  mult_div dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .funct(funct),
    .operand_1(op1), .operand_2(op2),
    .mult_div_done(done), .mult_div_result(res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {HI, LO} straight from the arithmetic definition of each instruction
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_MULT:  return 64'(sa * sb);
      F_DIVU:  return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic logic [5:0] rand_md();
    logic [1:0] s;
    s = 2'($urandom_range(0, 3));
    return {4'b0110, s};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Called on a negedge; done must appear exactly lat negedges later.
  // Operands and funct are scrambled while busy to prove they are ignored.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    funct = f; op1 = a; op2 = b;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat) begin
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " result"}, res, exp);
        last_res = exp;
      end else begin
        chk({tag, " done low"}, 64'(done), 64'd0);
      end
      if (k >= lat - 31 && k < lat - 6) begin
        funct = rand_md(); op1 = $urandom; op2 = $urandom;
      end else if (k >= lat - 6) begin
        funct = 6'h00;
      end
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, " done low"}, 64'(done), 64'd0);
    end
    chk({tag, " result held"}, res, last_res);
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;
    rst_n = 1'b0; flush = 1'b0; funct = 6'h00; op1 = 32'd0; op2 = 32'd0;
    last_res = 64'd0;
    #12;
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", res, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
    @(negedge clk);
    run_op("mult -3x5", F_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 33);
    run_op("mult b2b", F_MULT, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 34);
    @(negedge clk);
    run_op("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    @(negedge clk);
    run_op("div 7/-2", F_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    @(negedge clk);
    run_op("divu 7/0", F_DIVU, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF}, 33);
    @(negedge clk);
    run_op("div -5/0", F_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 33);
    @(negedge clk);
    run_op("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
    @(negedge clk);

    // Flush in busy cycle 10, then restart the same op
    funct = F_DIVU; op1 = 32'd100; op2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("flush pre done low", 64'(done), 64'd0);
      funct = 6'h00;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    expect_idle("flushed op", 40);
    run_op("divu restart", F_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    @(negedge clk);

    // Flush and start together must not start
    funct = F_MULTU; op1 = 32'd3; op2 = 32'd4; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; funct = 6'h00;
    expect_idle("flush+start", 40);

    // Non mult/div function codes leave the unit idle
    funct = 6'h20; op1 = $urandom; op2 = $urandom;
    expect_idle("non-md funct", 40);
    funct = 6'h00;

    // Reset in busy cycle 20
    funct = F_MULTU; op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      funct = 6'h00;
    end
    rst_n = 1'b0;
    #1;
    chk("mid-busy reset done", 64'(done), 64'd0);
    chk("mid-busy reset result", res, 64'd0);
    last_res = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("multu 3x4", F_MULTU, 32'd3, 32'd4, 64'd12, 33);

    for (int i = 0; i < 40; i++) begin
      f = rand_md(); a = pick_val(); b = pick_val();
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        run_op("rand", f, a, b, model(f, a, b), 33);
      end else begin
        run_op("rand b2b", f, a, b, model(f, a, b), 34);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have no parameters; widths are fixed: data 32 bits, result 64 bits, funct 6 bits.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  synchronous cancel of any operation in progress, e.g. on an exception.
REQ-006 funct  input  6  function code of the instruction currently held in EX.
REQ-007 operand_1  input  32  multiplicand or dividend (rs).
REQ-008 operand_2  input  32  multiplier or divisor (rt).
REQ-009 mult_div_done  output  1  result valid; EX releases its stall on this.
REQ-010 mult_div_result  output  64  [63:32] goes to HI and [31:0] goes to LO.

Function
REQ-011 SHALL have three states: IDLE, BUSY, DONE.
REQ-012 Start: in IDLE, SHALL start when funct is MULT, MULTU, DIV or DIVU and flush=0.
- On start, latch the absolute values of the operands (DIV/MULT only) and the two sign bits.
- On start, latch the op type, clear the 5-bit counter, and go to BUSY.
REQ-013 Operand sampling: operands SHALL be sampled only at start; changes on funct or operands during BUSY or DONE SHALL be ignored.
REQ-014 BUSY timing: SHALL perform one radix-2 iteration per cycle for exactly 32 cycles, then go to DONE.
- Multiply: shift-add on a 64-bit accumulator.
- Divide: restoring, using a 33-bit partial remainder.
REQ-015 Latency: if start is seen in cycle N, mult_div_done SHALL be 1 in cycle N+33 only.
REQ-016 mult_div_done SHALL equal (state==DONE) and be 0 in every other state.
REQ-017 DONE lasts one cycle, then returns to IDLE.
- An op in EX on the following cycle starts from IDLE normally, so back-to-back ops are allowed.
REQ-018 MULT signed result: the 64-bit product is negated if the operand signs differ.
REQ-019 MULTU result: the plain unsigned product.
REQ-020 DIV signed result: LO=quotient, negated if the signs differ; HI=remainder, taking the sign of the dividend.
REQ-021 DIVU result: LO=quotient, HI=remainder, both unsigned.
REQ-022 Divide by zero: SHALL give LO=0xFFFFFFFF and HI=dividend (as supplied) with normal latency; no exception is raised.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-024 Result timing: the sign correction SHALL be applied on the BUSY->DONE edge.
- mult_div_result is registered and holds its value until the next DONE.
REQ-025 Flush: flush=1 at a clock edge in any state SHALL force IDLE and clear the counter.
- mult_div_result keeps its value; mult_div_done is 0 from the next cycle.
REQ-026 Flush priority: flush and start in the same cycle SHALL not start.
REQ-027 Non-mult/div funct in IDLE SHALL leave the block idle with mult_div_done=0.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, counter=0, mult_div_done=0, mult_div_result=0, all internal registers=0.
REQ-029 Reset mid-BUSY SHALL abort the operation with no partial result visible.
REQ-030 After rst_n rises, the first op SHALL start on the first rising edge where the start condition holds.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF, start in cycle 0 -> done=1 only in cycle 33; result=0xFFFFFFFE_00000001.
REQ-032 MULT 0xFFFFFFFD(-3) x 5 -> result=0xFFFFFFFF_FFFFFFF1.
REQ-032 (cont.) Then immediately MULT 0x7FFFFFFF x 2 -> second done 34 cycles after the first; result=0x00000000_FFFFFFFE.
REQ-033 DIV 0xFFFFFFF9(-7) / 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-033 (cont.) DIV 7 / 0xFFFFFFFE -> HI=1, LO=0xFFFFFFFD.
REQ-034 DIVU 7 / 0 -> HI=7, LO=0xFFFFFFFF at cycle 33.
REQ-034 (cont.) DIV 0x80000000 / 0xFFFFFFFF -> HI=0, LO=0x80000000.
REQ-035 DIVU 100 / 7 with flush in BUSY cycle 10 -> done never asserted for that op and the old result is retained.
REQ-035 (cont.) Restart of DIVU 100 / 7 -> HI=2, LO=14 exactly 33 cycles after the restart.
REQ-036 rst_n low in BUSY cycle 20 -> done=0 and result=0 immediately.
REQ-036 (cont.) After release, MULTU 3 x 4 -> result=12 at cycle 33.
